// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one registered ALU between two requesters. Each requester offers
// operands plus an opcode; the winner is registered onto the ALU inputs, the
// block waits out the ALU latency, captures the result and returns it with
// the owning requester ID on a single response channel.
//
// Handshakes (request and response channels alike): a transfer happens on a
// rising clock edge where valid and ready are both high. A requester keeps
// valid/a/b/opcode stable until ready; it may drop valid before ready, in
// which case nothing is granted. The response side keeps rsp_valid_o,
// rsp_id_o and rsp_data_o stable until rsp_ready_i is seen high.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIORITY_EN  defined   -> requester 0 always wins ties
//                              undefined -> round-robin ties (default)
//
// Parameters:
//   DATA_WIDTH    operand/result width, must match the ALU
//   OPCODE_WIDTH  opcode width
//   ALU_LATENCY   posedges from ALU input change to registered ALU output (>=1)
//
// Ports:
//   clock_i, reset_n_i              clock, async active-low reset
//   reqN_valid_i / reqN_ready_o     request handshake, N = 0,1
//   reqN_a_i, reqN_b_i              operands
//   reqN_opcode_i                   opcode
//   alu_a_o, alu_b_o, alu_opcode_o  registered ALU inputs (hold between ops)
//   alu_result_i                    ALU output
//   rsp_valid_o / rsp_ready_i       response handshake
//   rsp_id_o, rsp_data_o            owning requester and captured result
//   busy_o                          high whenever the FSM is not IDLE
//   state_o                         FSM state for observation (IDLE/WAIT/RESP)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 5,
    parameter int ALU_LATENCY  = 1
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,

    input  logic                    req0_valid_i,
    output logic                    req0_ready_o,
    input  logic [DATA_WIDTH-1:0]   req0_a_i,
    input  logic [DATA_WIDTH-1:0]   req0_b_i,
    input  logic [OPCODE_WIDTH-1:0] req0_opcode_i,

    input  logic                    req1_valid_i,
    output logic                    req1_ready_o,
    input  logic [DATA_WIDTH-1:0]   req1_a_i,
    input  logic [DATA_WIDTH-1:0]   req1_b_i,
    input  logic [OPCODE_WIDTH-1:0] req1_opcode_i,

    output logic [DATA_WIDTH-1:0]   alu_a_o,
    output logic [DATA_WIDTH-1:0]   alu_b_o,
    output logic [OPCODE_WIDTH-1:0] alu_opcode_o,
    input  logic [DATA_WIDTH-1:0]   alu_result_i,

    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_id_o,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,

    output logic                    busy_o,
    output logic [1:0]              state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             grant0;
    logic             grant1;
    logic             accept;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
    // Requester 0 wins every tie; there is no fairness history.
    always_comb begin
        grant0 = req0_valid_i;
        grant1 = req1_valid_i && !req0_valid_i;
    end
`else
    // rr_last remembers the most recent winner; on a tie the other one wins.
    // It resets to 1 so requester 0 wins the first tie.
    logic rr_last;

    always_comb begin
        grant1 = req1_valid_i && (!req0_valid_i || !rr_last);
        grant0 = req0_valid_i && !grant1;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_last <= 1'b1;
        end else if (accept) begin
            rr_last <= grant1;
        end
    end
`endif

    assign accept = (state == ST_IDLE) && (grant0 || grant1);

    // Ready is offered only in IDLE and only to the winner. It is also masked
    // by the reset pin so every output reads 0 while reset is held.
    assign req0_ready_o = reset_n_i && (state == ST_IDLE) && grant0;
    assign req1_ready_o = reset_n_i && (state == ST_IDLE) && grant1;

    assign busy_o  = (state != ST_IDLE);
    assign state_o = state;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            alu_a_o      <= '0;
            alu_b_o      <= '0;
            alu_opcode_o <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= 1'b0;
            rsp_data_o   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a_o      <= grant1 ? req1_a_i      : req0_a_i;
                        alu_b_o      <= grant1 ? req1_b_i      : req0_b_i;
                        alu_opcode_o <= grant1 ? req1_opcode_i : req0_opcode_i;
                        rsp_id_o     <= grant1;
                        cnt          <= CNT_LOAD;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Count down the ALU latency, then sample the result one
                    // edge later, so the capture lands ALU_LATENCY+1 edges
                    // after the accept edge.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_data_o  <= alu_result_i;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps

module tb_alu_arbiter;

    localparam int DW  = 32;
    localparam int OW  = 5;
    localparam int LAT = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (latency 1) signals ----------------
    logic          r0_v, r0_rdy, r1_v, r1_rdy;
    logic [DW-1:0] r0_a, r0_b, r1_a, r1_b;
    logic [OW-1:0] r0_op, r1_op;
    logic [DW-1:0] alu_a, alu_b, alu_res;
    logic [OW-1:0] alu_op;
    logic          rsp_v, rsp_rdy, rsp_id, busy;
    logic [DW-1:0] rsp_d;
    logic [1:0]    st;

    // ---------------- DUT (latency 3) signals ----------------
    logic          q0_v, q0_rdy, q1_v, q1_rdy;
    logic [DW-1:0] q0_a, q0_b, q1_a, q1_b;
    logic [OW-1:0] q0_op, q1_op;
    logic [DW-1:0] qa, qb, q_res, s1, s2, s3;
    logic [OW-1:0] qop;
    logic          q_rv, q_rdy, q_rid, q_busy;
    logic [DW-1:0] q_rd;
    logic [1:0]    q_st;

    // ---------------- reference ALU behaviour ----------------
    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [OW-1:0] op);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // One registered stage for the latency-1 ALU, three for the latency-3 one.
    always @(posedge clk) alu_res <= alu_f(alu_a, alu_b, alu_op);
    always @(posedge clk) begin
        s1 <= alu_f(qa, qb, qop);
        s2 <= s1;
        s3 <= s2;
    end
    assign q_res = s3;

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .ALU_LATENCY(LAT)) dut (
        .clock_i(clk), .reset_n_i(reset_n),
        .req0_valid_i(r0_v), .req0_ready_o(r0_rdy), .req0_a_i(r0_a), .req0_b_i(r0_b), .req0_opcode_i(r0_op),
        .req1_valid_i(r1_v), .req1_ready_o(r1_rdy), .req1_a_i(r1_a), .req1_b_i(r1_b), .req1_opcode_i(r1_op),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_opcode_o(alu_op), .alu_result_i(alu_res),
        .rsp_valid_o(rsp_v), .rsp_ready_i(rsp_rdy), .rsp_id_o(rsp_id), .rsp_data_o(rsp_d),
        .busy_o(busy), .state_o(st)
    );

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .ALU_LATENCY(3)) dut3 (
        .clock_i(clk), .reset_n_i(reset_n),
        .req0_valid_i(q0_v), .req0_ready_o(q0_rdy), .req0_a_i(q0_a), .req0_b_i(q0_b), .req0_opcode_i(q0_op),
        .req1_valid_i(q1_v), .req1_ready_o(q1_rdy), .req1_a_i(q1_a), .req1_b_i(q1_b), .req1_opcode_i(q1_op),
        .alu_a_o(qa), .alu_b_o(qb), .alu_opcode_o(qop), .alu_result_i(q_res),
        .rsp_valid_o(q_rv), .rsp_ready_i(q_rdy), .rsp_id_o(q_rid), .rsp_data_o(q_rd),
        .busy_o(q_busy), .state_o(q_st)
    );

    // ---------------- scoreboard / model state ----------------
    int total = 0;
    int bad   = 0;

    logic [DW:0]   exp_q[$];      // {id, result} in issue order
    int            grants_q[$];   // observed grant order
    bit            m_free;        // block able to accept
    int            m_last;        // most recent winner
    int            m_cyc;         // posedges seen by the model
    int            m_due;         // model cycle at which the response shows up
    logic [DW-1:0] m_a, m_b;
    logic [OW-1:0] m_op;
    bit            acc0, acc1;    // grant taken during the last step

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_ready0"}, r0_rdy, 0);
        chk({pfx, "_ready1"}, r1_rdy, 0);
        chk({pfx, "_rsp_valid"}, rsp_v, 0);
        chk({pfx, "_rsp_id"}, rsp_id, 0);
        chk({pfx, "_rsp_data"}, rsp_d, 0);
        chk({pfx, "_alu_a"}, alu_a, 0);
        chk({pfx, "_alu_b"}, alu_b, 0);
        chk({pfx, "_alu_op"}, alu_op, 0);
        chk({pfx, "_busy"}, busy, 0);
    endtask

    task automatic model_reset();
        m_free = 1'b1;
        m_last = 1;
        exp_q.delete();
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    task automatic rand_op(output logic [DW-1:0] a, output logic [DW-1:0] b, output logic [OW-1:0] op);
        a  = $urandom;
        b  = $urandom;
        op = OW'($urandom_range(0, 5));
    endtask

    // Called at a falling edge with inputs already driven. Checks the DUT
    // against the model for this cycle, advances the model, and returns at
    // the next falling edge.
    task automatic step();
        logic        e0, e1, ev;
        logic [DW:0] f;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (m_free) begin
            if (r0_v && r1_v) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
                e0 = 1'b1;
`else
                if (m_last == 1) e0 = 1'b1;
                else             e1 = 1'b1;
`endif
            end else begin
                e0 = r0_v;
                e1 = r1_v;
            end
        end
        ev = !m_free && (m_cyc >= m_due);
        chk("ready0", r0_rdy, e0);
        chk("ready1", r1_rdy, e1);
        chk("busy", busy, !m_free);
        chk("rsp_valid", rsp_v, ev);
        if (!m_free) begin
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_op", alu_op, m_op);
        end
        if (ev) begin
            f = exp_q[0];
            chk("rsp_id", rsp_id, f[DW]);
            chk("rsp_data", rsp_d, f[DW-1:0]);
            if (rsp_rdy) begin
                void'(exp_q.pop_front());
                m_free = 1'b1;
            end
        end
        if ((r0_rdy && r0_v) || (r1_rdy && r1_v)) grants_q.push_back(r1_rdy ? 1 : 0);
        acc0 = e0;
        acc1 = e1;
        if (e0 || e1) begin
            m_a    = e1 ? r1_a  : r0_a;
            m_b    = e1 ? r1_b  : r0_b;
            m_op   = e1 ? r1_op : r0_op;
            exp_q.push_back({e1, alu_f(m_a, m_b, m_op)});
            m_due  = m_cyc + LAT + 2;
            m_free = 1'b0;
            m_last = e1 ? 1 : 0;
        end
        @(negedge clk);
        m_cyc++;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!rsp_v && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_rsp_timeout"}, (n < 20), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        r0_v = 1'b0;
        r1_v = 1'b0;
        rsp_rdy = 1'b0;
        #1;
        chk_zero("rst");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [DW-1:0] hold_d;
        logic          hold_id;
        logic [DW-1:0] ea;
        int            n;

        r0_v = 0; r1_v = 0; rsp_rdy = 0;
        r0_a = '0; r0_b = '0; r0_op = '0;
        r1_a = '0; r1_b = '0; r1_op = '0;
        q0_v = 0; q1_v = 0; q_rdy = 0;
        q0_a = '0; q0_b = '0; q0_op = '0;
        q1_a = '0; q1_b = '0; q1_op = '0;
        m_cyc = 0;
        m_due = 0;
        m_a = '0; m_b = '0; m_op = '0;
        model_reset();

        // Reset then a single ADD from requester 0.
        do_reset();
        r0_v = 1; r0_a = 32'h44e96cb8; r0_b = 32'h79adc30e; r0_op = 5'd0;
        #1;
        chk("t1_ready0_same_cycle", r0_rdy, 1);
        step();
        r0_v = 0;
        step();
        chk("t1_not_yet", rsp_v, 0);
        step();
        chk("t1_valid_after_2", rsp_v, 1);
        chk("t1_data", rsp_d, 32'hbe972fc6);
        chk("t1_id", rsp_id, 0);
        rsp_rdy = 1;
        step();

        // Both requesters valid back to back.
        do_reset();
        rsp_rdy = 1;
        r0_v = 1; r1_v = 1;
        rand_op(r0_a, r0_b, r0_op);
        rand_op(r1_a, r1_b, r1_op);
        grants_q.delete();
        for (int i = 0; i < 40 && grants_q.size() < 4; i++) begin
            step();
            if (acc0) rand_op(r0_a, r0_b, r0_op);
            if (acc1) rand_op(r1_a, r1_b, r1_op);
        end
        chk("t2_grant_count", grants_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            chk($sformatf("t2_grant%0d", k), grants_q[k], 0);
`else
            chk($sformatf("t2_grant%0d", k), grants_q[k], k % 2);
`endif
        end

        // Only requester 1, rr_last at its reset value.
        do_reset();
        rsp_rdy = 1;
        r1_v = 1;
        rand_op(r1_a, r1_b, r1_op);
        #1;
        chk("t3_ready1", r1_rdy, 1);
        step();
        r1_v = 0;
        wait_rsp("t3");
        chk("t3_id", rsp_id, 1);
        step();

        // Response held off for 5 cycles while both requesters wait.
        rsp_rdy = 0;
        r0_v = 1;
        rand_op(r0_a, r0_b, r0_op);
        step();
        r0_v = 0;
        wait_rsp("t4");
        hold_d  = rsp_d;
        hold_id = rsp_id;
        r0_v = 1; r1_v = 1;
        rand_op(r0_a, r0_b, r0_op);
        rand_op(r1_a, r1_b, r1_op);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_data_stable", rsp_d, hold_d);
            chk("t4_id_stable", rsp_id, hold_id);
            chk("t4_busy", busy, 1);
            chk("t4_ready0_low", r0_rdy, 0);
            chk("t4_ready1_low", r1_rdy, 0);
        end
        rsp_rdy = 1;
        step();
        chk("t4_idle_after_release", busy, 0);
        step();
        if (acc1) rand_op(r1_a, r1_b, r1_op);
        r1_v = 0;

        // Reset pulse while the last op is in WAIT.
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("t5");
        @(negedge clk);
        #1;
        chk("t5_no_rsp", rsp_v, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        r0_v = 1; r1_v = 1;
        rand_op(r0_a, r0_b, r0_op);
        rand_op(r1_a, r1_b, r1_op);
        #1;
        chk("t5_tie_ready0", r0_rdy, 1);
        chk("t5_tie_ready1", r1_rdy, 0);
        step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (acc0 || !r0_v) begin
                r0_v = ($urandom_range(0, 2) != 0);
                rand_op(r0_a, r0_b, r0_op);
            end else if ($urandom_range(0, 15) == 0) begin
                r0_v = 0;
            end
            if (acc1 || !r1_v) begin
                r1_v = ($urandom_range(0, 2) != 0);
                rand_op(r1_a, r1_b, r1_op);
            end else if ($urandom_range(0, 15) == 0) begin
                r1_v = 0;
            end
            rsp_rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        r0_v = 0; r1_v = 0; rsp_rdy = 1;
        for (int i = 0; i < 6; i++) step();

        // Latency-3 ALU.
        for (int k = 0; k < 4; k++) begin
            q0_v = 1;
            rand_op(q0_a, q0_b, q0_op);
            ea = alu_f(q0_a, q0_b, q0_op);
            #1;
            chk("t6_ready0", q0_rdy, 1);
            @(negedge clk);
            q0_v = 0;
            n = 0;
            while (!q_rv && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("t6_latency", n, 4);
            chk("t6_data", q_rd, ea);
            chk("t6_id", q_rid, 0);
            q_rdy = 1;
            @(negedge clk);
            q_rdy = 0;
            #1;
            chk("t6_idle", q_busy, 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
